gpio_port_ctrl: RTL and testbench

//  Register-mapped, parametrised GPIO bank; successor to the fixed 8-bit tri-state port.

---
 rtl/gpio_port_ctrl.sv | 164 ++++++++++++++++
 tb/tb_gpio_port_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port_ctrl.sv
// Register-mapped GPIO bank: direction/output registers, synchronised and
// optionally debounced pad inputs, per-bit edge interrupts with W1C status.
module gpio_port_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       bus_addr,
  input  logic             bus_we,
  input  logic             bus_re,
  input  logic [WIDTH-1:0] bus_wdata,
  output logic [WIDTH-1:0] bus_rdata,
  output logic             bus_rvalid,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DIR = 3'd0;
  localparam logic [2:0] ADDR_OUT = 3'd1;
  localparam logic [2:0] ADDR_IN  = 3'd2;
  localparam logic [2:0] ADDR_IEN = 3'd3;
  localparam logic [2:0] ADDR_REN = 3'd4;
  localparam logic [2:0] ADDR_FEN = 3'd5;
  localparam logic [2:0] ADDR_STS = 3'd6;
  localparam logic [2:0] ADDR_TGL = 3'd7;

  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] ren_q, ren_d;
  logic [WIDTH-1:0] fen_q, fen_d;
  logic [WIDTH-1:0] sts_q, sts_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] sts_clr;

  assign sync = sync_q[SYNC_STAGES-1];

  // Pad input synchroniser chain; pads are sampled whatever their direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_nodb
      assign filt = sync;
    end else begin : g_db
      localparam int CW = $clog2(DEBOUNCE + 1);
      logic [CW-1:0]    cnt_q [WIDTH];
      logic [CW-1:0]    cnt_d [WIDTH];
      logic [WIDTH-1:0] filt_q, filt_d;

      // Per-bit stability counter: a bit must differ for DEBOUNCE cycles in a row.
      always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_d[i] = '0;
          if (sync[i] != filt_q[i]) begin
            if (cnt_q[i] == CW'(DEBOUNCE - 1)) filt_d[i] = sync[i];
            else                               cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      end

      // Debounce state registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          filt_q <= '0;
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
          filt_q <= filt_d;
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
      end

      assign filt = filt_q;
    end
  endgenerate

  assign edge_set = (filt & ~prev_q & ren_q) | (~filt & prev_q & fen_q);

  // Register writes, W1C status (new edges win over a clear) and read mux.
  always_comb begin
    dir_d   = dir_q;
    out_d   = out_q;
    ien_d   = ien_q;
    ren_d   = ren_q;
    fen_d   = fen_q;
    sts_clr = '0;
    rdata_d = rdata_q;
    if (bus_we) begin
      unique case (bus_addr)
        ADDR_DIR: dir_d   = bus_wdata;
        ADDR_OUT: out_d   = bus_wdata;
        ADDR_IEN: ien_d   = bus_wdata;
        ADDR_REN: ren_d   = bus_wdata;
        ADDR_FEN: fen_d   = bus_wdata;
        ADDR_STS: sts_clr = bus_wdata;
        ADDR_TGL: out_d   = out_q ^ bus_wdata;
        default:  ;
      endcase
    end
    sts_d = (sts_q & ~sts_clr) | edge_set;
    if (bus_re) begin
      unique case (bus_addr)
        ADDR_DIR: rdata_d = dir_q;
        ADDR_OUT: rdata_d = out_q;
        ADDR_IN:  rdata_d = filt;
        ADDR_IEN: rdata_d = ien_q;
        ADDR_REN: rdata_d = ren_q;
        ADDR_FEN: rdata_d = fen_q;
        ADDR_STS: rdata_d = sts_q;
        ADDR_TGL: rdata_d = '0;
        default:  rdata_d = '0;
      endcase
    end
  end

  // Register file, edge history and read response flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q    <= '0;
      out_q    <= '0;
      ien_q    <= '0;
      ren_q    <= '0;
      fen_q    <= '0;
      sts_q    <= '0;
      prev_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      out_q    <= out_d;
      ien_q    <= ien_d;
      ren_q    <= ren_d;
      fen_q    <= fen_d;
      sts_q    <= sts_d;
      prev_q   <= filt;
      rdata_q  <= rdata_d;
      rvalid_q <= bus_re;
    end
  end

  assign pad_oe     = dir_q;
  assign pad_out    = out_q;
  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = |(sts_q & ien_q);

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Bench for gpio_port_ctrl: a bypass instance and a DEBOUNCE=4 instance share
// one bus and pad stimulus; the bypass instance is tracked by a reference model.
module tb_gpio_port_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] b_addr;
  logic       b_we, b_re;
  logic [7:0] b_wdata, b_pad;

  logic [7:0] r0_rdata, r0_oe, r0_out;
  logic       r0_rvalid, r0_irq;
  logic [7:0] r4_rdata, r4_oe, r4_out;
  logic       r4_rvalid, r4_irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_port_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(0)) u0 (
    .clk(clk), .reset(reset), .bus_addr(b_addr), .bus_we(b_we), .bus_re(b_re),
    .bus_wdata(b_wdata), .bus_rdata(r0_rdata), .bus_rvalid(r0_rvalid),
    .pad_in(b_pad), .pad_out(r0_out), .pad_oe(r0_oe), .irq(r0_irq)
  );

  gpio_port_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4)) u4 (
    .clk(clk), .reset(reset), .bus_addr(b_addr), .bus_we(b_we), .bus_re(b_re),
    .bus_wdata(b_wdata), .bus_rdata(r4_rdata), .bus_rvalid(r4_rvalid),
    .pad_in(b_pad), .pad_out(r4_out), .pad_oe(r4_oe), .irq(r4_irq)
  );

  // Reference model: register array by address, pad history queue.
  logic [7:0] m_regs [8];
  logic [7:0] m_padq [$];
  logic [7:0] m_filt, m_prev;
  logic [7:0] exp_rdata;
  logic       exp_rvalid;

  typedef struct {
    logic [2:0] addr;
    logic       we;
    logic       re;
    logic [7:0] wdata;
    logic [7:0] e_rdata;
    logic       e_rvalid;
    logic [7:0] e_oe;
    logic [7:0] e_out;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 8; a++) m_regs[a] = '0;
    m_padq.delete();
    m_padq.push_back(8'h00);
    m_padq.push_back(8'h00);
    m_filt     = '0;
    m_prev     = '0;
    exp_rdata  = '0;
    exp_rvalid = 1'b0;
  endtask

  task automatic model_edge();
    logic [7:0] rd, set, clr;
    rd = (b_addr == 3'd2) ? m_filt : (b_addr == 3'd7) ? 8'h00 : m_regs[b_addr];
    exp_rvalid = b_re;
    if (b_re) exp_rdata = rd;
    set = (m_filt & ~m_prev & m_regs[4]) | (~m_filt & m_prev & m_regs[5]);
    clr = '0;
    if (b_we) begin
      case (b_addr)
        3'd2: ;
        3'd6: clr = b_wdata;
        3'd7: m_regs[1] = m_regs[1] ^ b_wdata;
        default: m_regs[b_addr] = b_wdata;
      endcase
    end
    m_regs[6] = (m_regs[6] & ~clr) | set;
    m_prev = m_filt;
    m_padq.push_back(b_pad);
    void'(m_padq.pop_front());
    m_filt = m_padq[0];
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("m_oe",     r0_oe,     m_regs[0]);
    chk("m_out",    r0_out,    m_regs[1]);
    chk("m_irq",    r0_irq,    |(m_regs[6] & m_regs[3]));
    chk("m_rvalid", r0_rvalid, exp_rvalid);
    chk("m_rdata",  r0_rdata,  exp_rdata);
    chk("m4_oe",    r4_oe,     m_regs[0]);
    chk("m4_out",   r4_out,    m_regs[1]);
    chk("m4_rvalid", r4_rvalid, exp_rvalid);
  endtask

  task automatic bus(input logic [2:0] a, input logic we, input logic re, input logic [7:0] d);
    b_addr = a; b_we = we; b_re = re; b_wdata = d;
  endtask

  task automatic idle();
    bus(3'd0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    idle();
    #3 reset = 1'b1;
    #1;
    chk("rst_oe",     r0_oe,     0);
    chk("rst_out",    r0_out,    0);
    chk("rst_rdata",  r0_rdata,  0);
    chk("rst_rvalid", r0_rvalid, 0);
    chk("rst_irq",    r0_irq,    0);
    chk("rst4_oe",    r4_oe,     0);
    chk("rst4_irq",   r4_irq,    0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int first;
    tbl[0]  = '{3'd0, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0, 8'h0F, 8'h00};
    tbl[1]  = '{3'd1, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'h0F, 8'hA5};
    tbl[2]  = '{3'd1, 1'b0, 1'b1, 8'h00, 8'hA5, 1'b1, 8'h0F, 8'hA5};
    tbl[3]  = '{3'd0, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h0F, 8'hA5};
    tbl[4]  = '{3'd7, 1'b1, 1'b0, 8'hFF, 8'hA5, 1'b0, 8'h0F, 8'h5A};
    tbl[5]  = '{3'd7, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'h0F, 8'h5A};
    tbl[6]  = '{3'd0, 1'b0, 1'b1, 8'h00, 8'h0F, 1'b1, 8'h0F, 8'h5A};
    tbl[7]  = '{3'd2, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h0F, 8'h5A};
    tbl[8]  = '{3'd1, 1'b1, 1'b1, 8'h33, 8'h5A, 1'b1, 8'h0F, 8'h33};
    tbl[9]  = '{3'd1, 1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 8'h0F, 8'h33};
    tbl[10] = '{3'd3, 1'b1, 1'b1, 8'h81, 8'h00, 1'b1, 8'h0F, 8'h33};
    tbl[11] = '{3'd3, 1'b0, 1'b1, 8'h00, 8'h81, 1'b1, 8'h0F, 8'h33};

    reset = 1'b1;
    b_pad = 8'h00;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_oe",     r0_oe,     0);
    chk("init_out",    r0_out,    0);
    chk("init_rvalid", r0_rvalid, 0);
    chk("init_irq",    r0_irq,    0);
    reset = 1'b0;

    // Register map vectors.
    for (int i = 0; i < 12; i++) begin
      bus(tbl[i].addr, tbl[i].we, tbl[i].re, tbl[i].wdata);
      step();
      chk($sformatf("tbl%0d_rdata", i),  r0_rdata,  tbl[i].e_rdata);
      chk($sformatf("tbl%0d_rvalid", i), r0_rvalid, tbl[i].e_rvalid);
      chk($sformatf("tbl%0d_oe", i),     r0_oe,     tbl[i].e_oe);
      chk($sformatf("tbl%0d_out", i),    r0_out,    tbl[i].e_out);
      chk($sformatf("tbl%0d_irq", i),    r0_irq,    0);
    end

    // Rising edge on bit 3 with bypass debounce.
    do_reset();
    bus(3'd4, 1'b1, 1'b0, 8'h08); step();
    bus(3'd3, 1'b1, 1'b0, 8'h08); step();
    idle();
    b_pad = 8'h08;
    step(); chk("rise_irq_e1", r0_irq, 0);
    step(); chk("rise_irq_e2", r0_irq, 0);
    step(); chk("rise_irq_e3", r0_irq, 1);
    bus(3'd6, 1'b0, 1'b1, 8'h00); step(); chk("rise_sts", r0_rdata, 8'h08);
    bus(3'd6, 1'b1, 1'b0, 8'h08); step(); chk("w1c_irq", r0_irq, 0);
    idle();

    // Debounce: short glitch rejected, sustained level accepted after 2+4 cycles.
    b_pad = 8'h00;
    do_reset();
    bus(3'd4, 1'b1, 1'b0, 8'h01); step();
    bus(3'd5, 1'b1, 1'b0, 8'h01); step();
    idle();
    b_pad = 8'h01;
    repeat (3) step();
    b_pad = 8'h00;
    repeat (10) step();
    bus(3'd2, 1'b0, 1'b1, 8'h00); step(); chk("db_glitch_in", r4_rdata, 8'h00);
    bus(3'd6, 1'b0, 1'b1, 8'h00); step(); chk("db_glitch_sts", r4_rdata, 8'h00);
    b_pad = 8'h01;
    first = 0;
    bus(3'd2, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (first == 0 && r4_rdata[0]) first = i;
    end
    chk("db_latency", first, 7);
    bus(3'd6, 1'b0, 1'b1, 8'h00); step(); chk("db_sts", r4_rdata, 8'h01);
    idle();

    // Falling edge on bit 2 coinciding with a W1C of the same bit.
    b_pad = 8'h00;
    do_reset();
    bus(3'd5, 1'b1, 1'b0, 8'h04); step();
    idle();
    b_pad = 8'h04;
    repeat (4) step();
    b_pad = 8'h00;
    step();
    step();
    bus(3'd6, 1'b1, 1'b0, 8'h04); step();
    bus(3'd6, 1'b0, 1'b1, 8'h00); step(); chk("set_wins", r0_rdata, 8'h04);
    bus(3'd3, 1'b1, 1'b0, 8'h04); step(); chk("late_ien_irq", r0_irq, 1);
    bus(3'd6, 1'b1, 1'b0, 8'h04); step(); chk("clr_irq", r0_irq, 0);
    bus(3'd6, 1'b0, 1'b1, 8'h00); step(); chk("clr_sts", r0_rdata, 8'h00);
    idle();

    // Randomised traffic with a reset dropped in mid-stream.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
        bus(3'd2, 1'b0, 1'b1, 8'h00);
        step();
        chk("rst_in", r0_rdata, 8'h00);
        chk("rst_irq_after", r0_irq, 0);
      end
      bus(3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
          8'($urandom));
      if ($urandom_range(0, 3) == 0) b_pad = b_pad ^ 8'(1 << $urandom_range(0, 7));
      step();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
